// File: rtl/alu_serial_rx.sv
// -----------------------------------------------------------------------------
// alu_serial_rx
//
// Receives command frames for the ALU from a one-bit-per-clock serial line.
// Each frame carries eight DATA packets (operand B then operand A, MSB byte
// first) followed by one CMD packet holding the opcode and a CRC-4 over
// {B, A, 1'b1, OP}. Frame length, CRC and opcode are checked, and one decoded
// command per frame is presented with a single-cycle valid strobe.
//
// Packet on the wire (11 bits, MSB first):
//   start(0), type(0=DATA, 1=CMD), payload[7:0], stop(1)
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   sin      in   1   serial input, idle high
//   a_o      out  32  decoded operand A (held when a frame has an error)
//   b_o      out  32  decoded operand B (held when a frame has an error)
//   op_o     out  3   decoded opcode (held when a frame has an error)
//   err_o    out  3   {err_data, err_crc, err_op}, at most one bit set
//   valid_o  out  1   one-cycle strobe marking a_o/b_o/op_o/err_o valid
// -----------------------------------------------------------------------------
module alu_serial_rx #(
  parameter logic [3:0] CRC_POLY = 4'b0011,
  parameter logic [3:0] CRC_INIT = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [2:0]  op_o,
  output logic [2:0]  err_o,
  output logic        valid_o
);

  typedef enum logic [2:0] {IDLE, TYPE, PAYLOAD, STOP, DONE} state_e;

  state_e      state_q, state_d;
  logic        isCmd_q;
  logic [2:0]  bitCnt_q;
  logic [3:0]  dataCnt_q;
  logic [3:0]  crc_q;
  logic [7:0]  byte_q;
  logic [63:0] shift_q;
  logic [2:0]  opRx_q;
  logic [3:0]  crcRx_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q, err_q;
  logic [2:0]  errNext;

  // One step of the serial CRC-4 LFSR for a single message bit.
  function automatic logic [3:0] crcStep(input logic [3:0] c, input logic d);
    logic fb;
    fb = d ^ c[3];
    return {c[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0000);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. DONE watches for a start bit so a back-to-back packet
  // arriving with no idle gap is not lost.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!sin) state_d = TYPE;
      TYPE:    state_d = PAYLOAD;
      PAYLOAD: if (bitCnt_q == 3'd7) state_d = STOP;
      STOP:    state_d = (!sin || isCmd_q) ? DONE : IDLE;
      DONE:    state_d = (!sin) ? TYPE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error evaluation at the stop bit, highest priority wins. A low stop bit
  // is a framing error and is reported as err_data.
  always_comb begin
    errNext = 3'b000;
    if (!sin || dataCnt_q != 4'd8)
      errNext = 3'b100;
    else if (crc_q != crcRx_q)
      errNext = 3'b010;
    else if (!(opRx_q inside {3'b000, 3'b001, 3'b100, 3'b101}))
      errNext = 3'b001;
  end

  // Datapath. DATA payload bits feed the CRC as they arrive; in the CMD
  // payload the leading pad slot folds in the constant 1 of the message, the
  // next three bits are the opcode, and the last four are the received CRC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isCmd_q   <= 1'b0;
      bitCnt_q  <= 3'd0;
      dataCnt_q <= 4'd0;
      crc_q     <= CRC_INIT;
      byte_q    <= 8'd0;
      shift_q   <= 64'd0;
      opRx_q    <= 3'd0;
      crcRx_q   <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      op_q      <= 3'd0;
      err_q     <= 3'd0;
    end else begin
      unique case (state_q)
        TYPE: begin
          isCmd_q  <= sin;
          bitCnt_q <= 3'd0;
        end
        PAYLOAD: begin
          bitCnt_q <= bitCnt_q + 3'd1;
          byte_q   <= {byte_q[6:0], sin};
          if (!isCmd_q) begin
            crc_q <= crcStep(crc_q, sin);
          end else if (bitCnt_q == 3'd0) begin
            crc_q <= crcStep(crc_q, 1'b1);
          end else if (bitCnt_q <= 3'd3) begin
            crc_q  <= crcStep(crc_q, sin);
            opRx_q <= {opRx_q[1:0], sin};
          end else begin
            crcRx_q <= {crcRx_q[2:0], sin};
          end
        end
        STOP: begin
          if (sin && !isCmd_q) begin
            shift_q   <= {shift_q[55:0], byte_q};
            dataCnt_q <= (dataCnt_q == 4'd9) ? 4'd9 : dataCnt_q + 4'd1;
          end
          if (!sin || isCmd_q) begin
            err_q <= errNext;
            if (errNext == 3'b000) begin
              b_q  <= shift_q[63:32];
              a_q  <= shift_q[31:0];
              op_q <= opRx_q;
            end
          end
        end
        DONE: begin
          dataCnt_q <= 4'd0;
          crc_q     <= CRC_INIT;
        end
        default: ;
      endcase
    end
  end

  // Output logic: the strobe is the DONE state itself.
  always_comb begin
    valid_o = (state_q == DONE);
    a_o     = a_q;
    b_o     = b_q;
    op_o    = op_q;
    err_o   = err_q;
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_rx
//
// Drives serial frames into alu_serial_rx from a table of vectors and checks
// the decoded strobe, plus hand-written sequences for reset mid-frame and
// back-to-back frames with no idle gap.
// -----------------------------------------------------------------------------
module tb_alu_serial_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic [31:0] a_o, b_o;
  logic [2:0]  op_o, err_o;
  logic        valid_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          nData;
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    bit          useModel;
    logic [3:0]  crcField;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [2:0]  expOp;
    logic [2:0]  expErr;
  } vec_t;

  vec_t vecs[9];
  vec_t v;

  alu_serial_rx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sin     (sin),
    .a_o     (a_o),
    .b_o     (b_o),
    .op_o    (op_o),
    .err_o   (err_o),
    .valid_o (valid_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference CRC-4 (x^4+x+1) over the 68-bit message {B, A, 1'b1, OP}.
  function automatic logic [3:0] crcModel(input logic [31:0] b, input logic [31:0] a,
                                          input logic [2:0] op);
    logic [67:0] m;
    logic [3:0]  c;
    logic        fb;
    m = {b, a, 1'b1, op};
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = m[i] ^ c[3];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  // Drive one bit at a falling edge; it is sampled on the next rising edge.
  task automatic sendBit(input logic b);
    sin = b;
    @(negedge clk);
  endtask

  task automatic sendPacket(input logic isCmd, input logic [7:0] payload);
    sendBit(1'b0);
    sendBit(isCmd);
    for (int i = 7; i >= 0; i--) sendBit(payload[i]);
    sendBit(1'b1);
  endtask

  // Sends one frame; returns at the falling edge of the cycle the strobe
  // should be high.
  task automatic applyStimulus(input vec_t f);
    logic [63:0] ba;
    logic [3:0]  crc;
    int          nSend;
    ba    = {f.b, f.a};
    crc   = f.useModel ? (crcModel(f.b, f.a, f.op) ^ f.crcField) : f.crcField;
    nSend = (f.nData < 8) ? f.nData : 8;
    if (f.nData > 8) sendPacket(1'b0, 8'hA5);
    for (int k = 0; k < nSend; k++) sendPacket(1'b0, ba[63-8*k -: 8]);
    sendPacket(1'b1, {1'b0, f.op, crc});
  endtask

  task automatic checkOutput(input vec_t f, input string tag);
    check({tag, " valid"}, {31'd0, valid_o}, 32'd1);
    check({tag, " a_o"},   a_o, f.expA);
    check({tag, " b_o"},   b_o, f.expB);
    check({tag, " op_o"},  {29'd0, op_o},  {29'd0, f.expOp});
    check({tag, " err_o"}, {29'd0, err_o}, {29'd0, f.expErr});
  endtask

  task automatic idleCheck(input string tag);
    sin = 1'b1;
    @(negedge clk);
    check({tag, " valid low"}, {31'd0, valid_o}, 32'd0);
  endtask

  task automatic checkZero(input string tag);
    check({tag, " a_o"},   a_o, 32'd0);
    check({tag, " b_o"},   b_o, 32'd0);
    check({tag, " op_o"},  {29'd0, op_o},  32'd0);
    check({tag, " err_o"}, {29'd0, err_o}, 32'd0);
    check({tag, " valid"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    //          nData  B             A             op      model crc    expA          expB          expOp   expErr
    vecs[0] = '{8, 32'h0000_0000, 32'h0000_0000, 3'b000, 1'b0, 4'b1011, 32'h0000_0000, 32'h0000_0000, 3'b000, 3'b000};
    vecs[1] = '{8, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, 4'b0000, 32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 3'b000};
    vecs[2] = '{8, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, 4'b0001, 32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 3'b010};
    vecs[3] = '{7, 32'h1111_2222, 32'h3333_4444, 3'b000, 1'b1, 4'b0000, 32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 3'b100};
    vecs[4] = '{9, 32'h1111_2222, 32'h3333_4444, 3'b000, 1'b1, 4'b0000, 32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 3'b100};
    vecs[5] = '{8, 32'h1234_5678, 32'h9ABC_DEF0, 3'b111, 1'b1, 4'b0000, 32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 3'b001};
    vecs[6] = '{8, 32'h1234_5678, 32'h9ABC_DEF0, 3'b111, 1'b1, 4'b0110, 32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 3'b010};
    vecs[7] = '{8, 32'hDEAD_BEEF, 32'h0000_0005, 3'b101, 1'b1, 4'b0000, 32'h0000_0005, 32'hDEAD_BEEF, 3'b101, 3'b000};
    vecs[8] = '{8, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b001, 1'b1, 4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b001, 3'b000};

    sin   = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
      idleCheck($sformatf("vec%0d", i));
    end

    // Reset asserted part way through the 4th DATA packet.
    sendPacket(1'b0, 8'h11);
    sendPacket(1'b0, 8'h22);
    sendPacket(1'b0, 8'h33);
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sin   = 1'b1;
    rst_n = 1'b0;
    #1;
    checkZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{8, 32'hCAFE_F00D, 32'h8000_0000, 3'b000, 1'b1, 4'b0000,
          32'h8000_0000, 32'hCAFE_F00D, 3'b000, 3'b000};
    applyStimulus(v);
    checkOutput(v, "postreset");
    idleCheck("postreset");

    // Back-to-back frames: second start bit lands in the strobe cycle.
    v = '{8, 32'h7FFF_FFFF, 32'h8000_0001, 3'b100, 1'b1, 4'b0000,
          32'h8000_0001, 32'h7FFF_FFFF, 3'b100, 3'b000};
    applyStimulus(v);
    checkOutput(v, "b2b first");
    v = '{8, 32'h0000_0001, 32'h0000_0002, 3'b101, 1'b1, 4'b0000,
          32'h0000_0002, 32'h0000_0001, 3'b101, 3'b000};
    applyStimulus(v);
    checkOutput(v, "b2b second");
    idleCheck("b2b second");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
